alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised multi-cycle ALU: successor to the 8-bit combinational datapath ALU, generalised to W-bit operands. It adds logic ops, variable-distance shifts and an iterative multiplier, and has an explicit valid/ready handshake so the control unit can stall on multi-cycle ops. It sits between the register file read ports and the writeback/status-register update path. The status-byte layout stays compatible: bit0 EQ, bit1 Z; bits 2 and 3 are now defined.

## Interface
- W, default 8: operand/result width (≥4).
- SW, default 8: status word width (≥4).
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operation request.
- in_ready  out  1  block accepts a request this cycle.
- aop  in  5  opcode, sampled on accept.
- x, y  in  W each  operands, sampled on accept.
- s  in  SW  current status word, sampled on accept.
- out_valid  out  1  result valid; held until taken.
- out_ready  in  1  consumer takes result.
- o  out  W  result.
- os  out  SW  updated status word.

## Operation
- Opcodes:
  - RETX=0: o=x.
  - RETY=1: o=y.
  - ADD=2: x+y.
  - SUB=3: x−y.
  - CMP=4: o=x.
  - SHL=5: x<<n.
  - AND=6.
  - OR=7.
  - XOR=8.
  - SHR=9: logical x>>n.
  - MUL=10: low W bits of x*y.
  - Others behave as RETX.
- Shift distance n = y mod W (low clog2(W) bits of y).
- Flags: EQ=bit0, Z=bit1, C=bit2, N=bit3. Bits SW−1:4 always pass through from s.
- RETX/RETY/default: os=s.
- ADD: Z=(o==0), C=carry out, N=o[W−1]; EQ passes through.
- SUB: Z, N as ADD; C=borrow (x<y unsigned); EQ passes through.
- CMP: EQ=(x==y); Z, C, N pass through.
- AND/OR/XOR: Z, N updated; C cleared; EQ passes through.
- SHL/SHR: Z, N updated. C = last bit shifted out; C=0 when n=0. EQ passes through.
- MUL: Z=(o==0), N=o[W−1], C=(upper W bits of full product ≠0); EQ passes through.
- Operands, aop and s are latched at accept; later input changes are ignored.
- FSM:
  - IDLE: in_ready=1. On accept:
    - SHL/SHR with n≠0 → EXEC, count=n.
    - MUL → EXEC, count=W.
    - All other ops → DONE.
  - EXEC: in_ready=0. One shift bit, or one shift-add step, per cycle. Count decrements; at 0 → DONE.
  - DONE: out_valid=1, o/os stable. out_ready=1 → IDLE. Also accepts a new request the same cycle when in_valid=1: in_ready=out_ready in DONE.

## Timing
- Reset values: o=0, os=0, out_valid=0, in_ready=1, state IDLE, count=0.
- Single-cycle ops and zero-distance shifts: accept at edge k; out_valid=1 after edge k+1.
- Shifts: out_valid after edge k+n+1.
- MUL: out_valid after edge k+W+1.
- Back-to-back single-cycle ops with out_ready held high sustain one result per cycle: DONE→DONE via the accept path.
- Backpressure: out_valid stays high and o/os hold indefinitely while out_ready=0.
- in_valid during EXEC is not accepted (in_ready=0); the requester must hold it.
- rst asserted mid-EXEC or mid-DONE aborts immediately: outputs go to reset values and the pending result is lost.
- All arithmetic is unsigned modulo 2^W, except the N flag and the MUL product width (2W internal).

## Structure
- Shared package alu_pkg:
  - opcode constants, 5 bits;
  - flag bit indices FLAG_EQ=0, FLAG_Z=1, FLAG_C=2, FLAG_N=3;
  - FSM state encoding.
- Sub-module mul_iter (W parameter):
  - one shift-add multiplier step per cycle;
  - start/done pulses;
  - 2W product out.
- The top level owns the FSM, the shifter (single-bit-per-cycle register) and flag generation.

## Test plan
- W=8, ADD x=0xFF y=0x01 s=0x00, out_ready=1 → o=0x00, os=0x06 (Z, C) one cycle after accept; then SUB x=0x05 y=0x07 s=0xF0 → o=0xFE, os=0xFC.
- CMP x=0x3C y=0x3C s=0x0E → o=0x3C, os=0x0F. Then CMP x=0x3C y=0x3D s=0x0F → os=0x0E.
- SHL x=0x81 y=0x01 → o=0x02, C=1, out_valid 2 cycles after accept. SHR x=0x81 y=0x08 (n=0) → o=0x81, C=0, N=1, latency 1.
- MUL x=0x10 y=0x11 s=0x00 → o=0x10, os=0x04. out_valid exactly 9 cycles after accept; in_ready=0 throughout EXEC; in_valid pulses during EXEC are ignored.
- Backpressure: hold out_ready=0 for 5 cycles after an XOR 0xAA^0xFF → o=0x55 stable, out_valid high. Release out_ready with a new in_valid the same cycle → second op accepted that edge.
- Assert rst 3 cycles into a MUL → out_valid=0, o=0, os=0, in_ready=1 next cycle. A following ADD 0x02+0x03 returns 0x05.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// alu_pkg: shared definitions for the sequential ALU.
//   - 5-bit opcode constants
//   - status-word flag bit indices
//   - FSM state encoding
//   - is_shift(): true for the variable-distance shift opcodes
package alu_pkg;

    localparam logic [4:0] OP_RETX = 5'd0;
    localparam logic [4:0] OP_RETY = 5'd1;
    localparam logic [4:0] OP_ADD  = 5'd2;
    localparam logic [4:0] OP_SUB  = 5'd3;
    localparam logic [4:0] OP_CMP  = 5'd4;
    localparam logic [4:0] OP_SHL  = 5'd5;
    localparam logic [4:0] OP_AND  = 5'd6;
    localparam logic [4:0] OP_OR   = 5'd7;
    localparam logic [4:0] OP_XOR  = 5'd8;
    localparam logic [4:0] OP_SHR  = 5'd9;
    localparam logic [4:0] OP_MUL  = 5'd10;

    localparam int FLAG_EQ = 0;
    localparam int FLAG_Z  = 1;
    localparam int FLAG_C  = 2;
    localparam int FLAG_N  = 3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic logic is_shift(input logic [4:0] op);
        return (op == OP_SHL) || (op == OP_SHR);
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: request/response bundle between the control unit and alu_seq.
//   Request : in_valid, in_ready, aop, x, y, s
//   Response: out_valid, out_ready, o, os
//   master = control unit side, slave = ALU side.
interface alu_seq_if #(
    parameter int W  = 8,
    parameter int SW = 8
);
    logic          in_valid;
    logic          in_ready;
    logic [4:0]    aop;
    logic [W-1:0]  x;
    logic [W-1:0]  y;
    logic [SW-1:0] s;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  o;
    logic [SW-1:0] os;

    modport master (
        output in_valid, aop, x, y, s, out_ready,
        input  in_ready, out_valid, o, os
    );

    modport slave (
        input  in_valid, aop, x, y, s, out_ready,
        output in_ready, out_valid, o, os
    );
endinterface

// File: rtl/alu_seq_mul.sv
// mul_iter: iterative shift-add multiplier, one partial product per cycle.
//   clk, rst   : clock, async active-high reset
//   start_i    : load operands (pulse)
//   a_i, b_i   : W-bit unsigned operands
//   done_o     : high during the final step cycle
//   product_o  : 2W-bit product; valid while done_o is high
module mul_iter #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start_i,
    input  logic [W-1:0]   a_i,
    input  logic [W-1:0]   b_i,
    output logic           done_o,
    output logic [2*W-1:0] product_o
);
    localparam int CW = $clog2(W + 1);

    logic           busy_q;
    logic [CW-1:0]  cnt_q;
    logic [2*W-1:0] acc_q, acc_d;
    logic [2*W-1:0] mcand_q;
    logic [W-1:0]   mplier_q;

    // Product is presented combinationally so the caller can capture it at
    // the same edge that retires the last step.
    always_comb begin
        acc_d     = acc_q + (mplier_q[0] ? mcand_q : '0);
        done_o    = busy_q && (cnt_q == CW'(1));
        product_o = acc_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else if (start_i) begin
            busy_q   <= 1'b1;
            cnt_q    <= CW'(W);
            acc_q    <= '0;
            mcand_q  <= {{W{1'b0}}, a_i};
            mplier_q <= b_i;
        end else if (busy_q) begin
            acc_q    <= acc_d;
            mcand_q  <= {mcand_q[2*W-2:0], 1'b0};
            mplier_q <= {1'b0, mplier_q[W-1:1]};
            cnt_q    <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) busy_q <= 1'b0;
        end
    end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: W-bit multi-cycle ALU with valid/ready handshake.
//   clk, rst : clock, async active-high reset
//   bus      : alu_seq_if.slave (in_valid/in_ready/aop/x/y/s request,
//              out_valid/out_ready/o/os response)
// Single-cycle ops go straight to DONE; shifts step one bit per cycle and
// MUL runs through mul_iter while the FSM sits in EXEC.
module alu_seq
    import alu_pkg::*;
#(
    parameter int W  = 8,
    parameter int SW = 8
) (
    input  logic       clk,
    input  logic       rst,
    alu_seq_if.slave   bus
);
    localparam int NB = $clog2(W);
    localparam int CW = $clog2(W + 1);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [4:0]    op_q, op_d;
    logic [W-1:0]  x_q, x_d;
    logic [SW-1:0] s_q, s_d;
    logic [W-1:0]  o_q, o_d;
    logic [SW-1:0] os_q, os_d;

    logic           in_ready_c, accept;
    logic [NB-1:0]  n_in;
    logic [W-1:0]   sh_next;
    logic           sh_out;
    logic           mul_start, mul_done;
    logic [2*W-1:0] prod;

    logic [4:0]    op_c;
    logic [W-1:0]  a_c, b_c, shv_c, res;
    logic [SW-1:0] s_c, res_s;
    logic          shb_c;
    logic [W:0]    sum;

    mul_iter #(.W(W)) u_mul (
        .clk       (clk),
        .rst       (rst),
        .start_i   (mul_start),
        .a_i       (bus.x),
        .b_i       (bus.y),
        .done_o    (mul_done),
        .product_o (prod)
    );

    assign in_ready_c    = (state_q == ST_IDLE) || ((state_q == ST_DONE) && bus.out_ready);
    assign accept        = bus.in_valid && in_ready_c;
    assign n_in          = bus.y[NB-1:0];
    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.o         = o_q;
    assign bus.os        = os_q;

    // One-bit shifter step; sh_out is the bit leaving the register.
    always_comb begin
        sh_next = (op_q == OP_SHL) ? {x_q[W-2:0], 1'b0} : {1'b0, x_q[W-1:1]};
        sh_out  = (op_q == OP_SHL) ? x_q[W-1] : x_q[0];
    end

    // Result and flag generation. Operands come from the bus on an accept,
    // or from the latched op/status when an EXEC op retires.
    always_comb begin
        op_c  = bus.aop;
        a_c   = bus.x;
        b_c   = bus.y;
        s_c   = bus.s;
        shv_c = bus.x;
        shb_c = 1'b0;
        if (state_q == ST_EXEC) begin
            op_c  = op_q;
            a_c   = x_q;
            b_c   = '0;
            s_c   = s_q;
            shv_c = sh_next;
            shb_c = sh_out;
        end
        res   = a_c;
        res_s = s_c;
        sum   = '0;
        case (op_c)
            OP_RETY: res = b_c;
            OP_ADD: begin
                sum = {1'b0, a_c} + {1'b0, b_c};
                res = sum[W-1:0];
                res_s[FLAG_C] = sum[W];
            end
            OP_SUB: begin
                res = a_c - b_c;
                res_s[FLAG_C] = (a_c < b_c);
            end
            OP_CMP: res_s[FLAG_EQ] = (a_c == b_c);
            OP_SHL, OP_SHR: begin
                res = shv_c;
                res_s[FLAG_C] = shb_c;
            end
            OP_AND: begin
                res = a_c & b_c;
                res_s[FLAG_C] = 1'b0;
            end
            OP_OR: begin
                res = a_c | b_c;
                res_s[FLAG_C] = 1'b0;
            end
            OP_XOR: begin
                res = a_c ^ b_c;
                res_s[FLAG_C] = 1'b0;
            end
            OP_MUL: begin
                res = prod[W-1:0];
                res_s[FLAG_C] = |prod[2*W-1:W];
            end
            default: ;
        endcase
        if ((op_c >= OP_ADD) && (op_c <= OP_MUL) && (op_c != OP_CMP)) begin
            res_s[FLAG_Z] = (res == '0);
            res_s[FLAG_N] = res[W-1];
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        op_d      = op_q;
        x_d       = x_q;
        s_d       = s_q;
        o_d       = o_q;
        os_d      = os_q;
        mul_start = 1'b0;
        case (state_q)
            ST_EXEC: begin
                x_d     = sh_next;
                count_d = count_q - CW'(1);
                if ((op_q == OP_MUL) ? mul_done : (count_q == CW'(1))) begin
                    state_d = ST_DONE;
                    o_d     = res;
                    os_d    = res_s;
                end
            end
            default: begin
                if ((state_q == ST_DONE) && bus.out_ready) state_d = ST_IDLE;
                // DONE with out_ready also takes a new request here, which is
                // what allows one result per cycle for single-cycle ops.
                if (accept) begin
                    op_d = bus.aop;
                    x_d  = bus.x;
                    s_d  = bus.s;
                    if (is_shift(bus.aop) && (n_in != '0)) begin
                        state_d = ST_EXEC;
                        count_d = CW'(n_in);
                    end else if (bus.aop == OP_MUL) begin
                        state_d   = ST_EXEC;
                        count_d   = CW'(W);
                        mul_start = 1'b1;
                    end else begin
                        state_d = ST_DONE;
                        o_d     = res;
                        os_d    = res_s;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            op_q    <= '0;
            x_q     <= '0;
            s_q     <= '0;
            o_q     <= '0;
            os_q    <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            op_q    <= op_d;
            x_q     <= x_d;
            s_q     <= s_d;
            o_q     <= o_d;
            os_q    <= os_d;
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vector table for alu_seq (W=8, SW=8) plus hand-written
// sequences for EXEC stalling, backpressure, back-to-back issue and reset abort.
module tb_alu_seq;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    alu_seq_if #(.W(8), .SW(8)) bus ();

    alu_seq #(.W(8), .SW(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] aop;
        logic [7:0] x;
        logic [7:0] y;
        logic [7:0] s;
        logic [7:0] eo;
        logic [7:0] eos;
        int         lat;
    } vec_t;

    vec_t vecs[20];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge where the result is seen.
    task automatic run_op(input string name, input logic [4:0] aop, input logic [7:0] x,
                          input logic [7:0] y, input logic [7:0] s,
                          input logic [7:0] eo, input logic [7:0] eos, input int elat);
        int lat;
        bus.in_valid  = 1'b1;
        bus.aop       = aop;
        bus.x         = x;
        bus.y         = y;
        bus.s         = s;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({name, "_lat"}, lat, elat);
        check({name, "_o"}, bus.o, eo);
        check({name, "_os"}, bus.os, eos);
    endtask

    initial begin
        int lat;
        logic [7:0] b2b_o[3];
        logic [7:0] b2b_x[3];
        logic [7:0] b2b_y[3];

        vecs[0]  = '{OP_ADD,  8'hFF, 8'h01, 8'h00, 8'h00, 8'h06, 1};
        vecs[1]  = '{OP_SUB,  8'h05, 8'h07, 8'hF0, 8'hFE, 8'hFC, 1};
        vecs[2]  = '{OP_CMP,  8'h3C, 8'h3C, 8'h0E, 8'h3C, 8'h0F, 1};
        vecs[3]  = '{OP_CMP,  8'h3C, 8'h3D, 8'h0F, 8'h3C, 8'h0E, 1};
        vecs[4]  = '{OP_SHL,  8'h81, 8'h01, 8'h00, 8'h02, 8'h04, 2};
        vecs[5]  = '{OP_SHR,  8'h81, 8'h08, 8'h00, 8'h81, 8'h08, 1};
        vecs[6]  = '{OP_MUL,  8'h10, 8'h11, 8'h00, 8'h10, 8'h04, 9};
        vecs[7]  = '{OP_XOR,  8'hAA, 8'hFF, 8'h00, 8'h55, 8'h00, 1};
        vecs[8]  = '{OP_RETY, 8'h12, 8'h34, 8'h5A, 8'h34, 8'h5A, 1};
        vecs[9]  = '{OP_AND,  8'hF0, 8'h0F, 8'h04, 8'h00, 8'h02, 1};
        vecs[10] = '{OP_OR,   8'h80, 8'h01, 8'h11, 8'h81, 8'h19, 1};
        vecs[11] = '{OP_SHR,  8'h84, 8'h03, 8'h00, 8'h10, 8'h04, 4};
        vecs[12] = '{OP_SHL,  8'h03, 8'h0F, 8'h00, 8'h80, 8'h0C, 8};
        vecs[13] = '{5'h1F,   8'h77, 8'h00, 8'h33, 8'h77, 8'h33, 1};
        vecs[14] = '{OP_MUL,  8'hFF, 8'hFF, 8'hF0, 8'h01, 8'hF4, 9};
        vecs[15] = '{OP_MUL,  8'h00, 8'h05, 8'h00, 8'h00, 8'h02, 9};
        vecs[16] = '{OP_SUB,  8'h07, 8'h07, 8'h01, 8'h00, 8'h03, 1};
        vecs[17] = '{OP_ADD,  8'h7F, 8'h01, 8'h00, 8'h80, 8'h08, 1};
        vecs[18] = '{OP_RETX, 8'h5A, 8'h00, 8'hF0, 8'h5A, 8'hF0, 1};
        vecs[19] = '{OP_SHL,  8'h40, 8'h09, 8'h00, 8'h80, 8'h08, 2};

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.aop       = '0;
        bus.x         = '0;
        bus.y         = '0;
        bus.s         = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_in_ready", bus.in_ready, 1'b1);
        check("rst_o", bus.o, 8'h00);
        check("rst_os", bus.os, 8'h00);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 20; i++)
            run_op($sformatf("vec%0d", i), vecs[i].aop, vecs[i].x, vecs[i].y, vecs[i].s,
                   vecs[i].eo, vecs[i].eos, vecs[i].lat);

        // MUL with in_valid pulses and changing operands during EXEC.
        @(negedge clk);
        bus.in_valid = 1'b1; bus.aop = OP_MUL; bus.x = 8'h10; bus.y = 8'h11; bus.s = 8'h00;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 40) begin
            check($sformatf("mulexec_in_ready_%0d", lat), bus.in_ready, 1'b0);
            if (lat >= 2 && lat <= 4) begin
                bus.in_valid = 1'b1; bus.aop = OP_ADD; bus.x = 8'h01; bus.y = 8'h01;
            end else begin
                bus.in_valid = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        bus.in_valid = 1'b0;
        check("mulexec_lat", lat, 9);
        check("mulexec_o", bus.o, 8'h10);
        check("mulexec_os", bus.os, 8'h04);

        // Backpressure: result held while out_ready is low.
        @(negedge clk);
        bus.in_valid = 1'b1; bus.aop = OP_XOR; bus.x = 8'hAA; bus.y = 8'hFF; bus.s = 8'h00;
        bus.out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("bp_first_valid", bus.out_valid, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("bp_hold_valid_%0d", i), bus.out_valid, 1'b1);
            check($sformatf("bp_hold_o_%0d", i), bus.o, 8'h55);
            check($sformatf("bp_hold_in_ready_%0d", i), bus.in_ready, 1'b0);
        end
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1; bus.aop = OP_ADD; bus.x = 8'h01; bus.y = 8'h02; bus.s = 8'h00;
        #1;
        check("bp_release_in_ready", bus.in_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("bp_next_valid", bus.out_valid, 1'b1);
        check("bp_next_o", bus.o, 8'h03);
        check("bp_next_os", bus.os, 8'h00);

        // Back-to-back single-cycle ops: one result per cycle.
        b2b_x = '{8'h10, 8'h20, 8'hFF};
        b2b_y = '{8'h01, 8'h02, 8'h02};
        b2b_o = '{8'h11, 8'h22, 8'h01};
        @(negedge clk);
        bus.in_valid = 1'b1; bus.aop = OP_ADD; bus.s = 8'h00;
        bus.x = b2b_x[0]; bus.y = b2b_y[0];
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("b2b_valid_%0d", i), bus.out_valid, 1'b1);
            check($sformatf("b2b_o_%0d", i), bus.o, b2b_o[i]);
            if (i < 2) begin
                bus.x = b2b_x[i+1];
                bus.y = b2b_y[i+1];
            end else begin
                bus.in_valid = 1'b0;
            end
        end
        check("b2b_last_os", bus.os, 8'h04);

        // Reset three cycles into a MUL aborts it.
        @(negedge clk);
        bus.in_valid = 1'b1; bus.aop = OP_MUL; bus.x = 8'h10; bus.y = 8'h11; bus.s = 8'h00;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_out_valid", bus.out_valid, 1'b0);
        check("abort_o", bus.o, 8'h00);
        check("abort_os", bus.os, 8'h00);
        check("abort_in_ready", bus.in_ready, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("after_abort_out_valid", bus.out_valid, 1'b0);
        check("after_abort_in_ready", bus.in_ready, 1'b1);
        run_op("after_abort_add", OP_ADD, 8'h02, 8'h03, 8'h00, 8'h05, 8'h00, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
